// File: rtl/ladder_pkg.sv
// Shared types and constants for the Montgomery-ladder swap controller.
package ladder_pkg;

  localparam int WID_DEF = 256;

  // Per-bit swap decision, replicated across the mask width by the controller.
  localparam logic SWAP_BIT = 1'b1;
  localparam logic PASS_BIT = 1'b0;

  localparam logic [WID_DEF-1:0] MASK_ALL  = '1;
  localparam logic [WID_DEF-1:0] MASK_NONE = '0;

  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    WSWAP,
    STEP,
    WSTEP,
    FINAL,
    WFINAL,
    DONE
  } state_t;

endpackage

// File: rtl/ladder_swap_ctrl.sv
// Constant-time Montgomery-ladder initiator: one cswap + one ladder step per scalar bit, MSB first.
// Optional watchdog with err output is enabled by defining LADDER_TMO_EN.
module ladder_swap_ctrl
  import ladder_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int IDXW = 8
`ifdef LADDER_TMO_EN
  , parameter int TMO_CYC = 1024
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WID-1:0]  scalar,
  output logic            cs_en,
  output logic [WID-1:0]  cs_swap,
  input  logic            cs_vld,
  output logic            step_en,
  input  logic            step_done,
  output logic [IDXW-1:0] bit_idx,
  output logic            busy,
  output logic            done
`ifdef LADDER_TMO_EN
  , output logic          err
`endif
);

  state_t         state;
  logic [WID-1:0] k_reg;
  logic           prev_reg;
  logic           k_bit;
  logic           k_bit_lo;

  assign k_bit    = k_reg[bit_idx];
  // Next lower scalar bit; only consumed when bit_idx is non-zero.
  assign k_bit_lo = k_reg[bit_idx - IDXW'(1)];

`ifdef LADDER_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting;
  logic          resp;
  logic          tmo_hit;

  assign waiting = (state == WSWAP) || (state == WSTEP) || (state == WFINAL);
  assign resp    = (state == WSTEP) ? step_done : cs_vld;
  assign tmo_hit = waiting && !resp && (tmo_cnt == TW'(TMO_CYC - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k_reg    <= '0;
      prev_reg <= PASS_BIT;
      bit_idx  <= '0;
      cs_en    <= 1'b0;
      cs_swap  <= '0;
      step_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef LADDER_TMO_EN
      tmo_cnt  <= '0;
      err      <= 1'b0;
`endif
    end else begin
      cs_en   <= 1'b0;
      step_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_reg    <= scalar;
            bit_idx  <= IDXW'(WID - 1);
            prev_reg <= PASS_BIT;
            busy     <= 1'b1;
            cs_en    <= 1'b1;
            cs_swap  <= {WID{scalar[WID-1] ^ PASS_BIT}};
            state    <= SWAP;
`ifdef LADDER_TMO_EN
            err      <= 1'b0;
`endif
          end
        end
        SWAP:  state <= WSWAP;
        WSWAP: begin
          if (cs_vld) begin
            step_en <= 1'b1;
            state   <= STEP;
          end
        end
        STEP:  state <= WSTEP;
        WSTEP: begin
          if (step_done) begin
            prev_reg <= k_bit;
            cs_en    <= 1'b1;
            if (bit_idx == '0) begin
              cs_swap <= {WID{k_bit}};
              state   <= FINAL;
            end else begin
              // Mask for the next bit depends on the bit just finished (the new prev).
              bit_idx <= bit_idx - IDXW'(1);
              cs_swap <= {WID{k_bit_lo ^ k_bit}};
              state   <= SWAP;
            end
          end
        end
        FINAL: state <= WFINAL;
        WFINAL: begin
          if (cs_vld) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          cs_swap <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef LADDER_TMO_EN
      // Every wait state is entered from a non-wait state, so clearing outside waits covers entry.
      tmo_cnt <= (waiting && !resp) ? tmo_cnt + TW'(1) : '0;
      if (tmo_hit) begin
        err     <= 1'b1;
        busy    <= 1'b0;
        cs_en   <= 1'b0;
        step_en <= 1'b0;
        cs_swap <= '0;
        tmo_cnt <= '0;
        state   <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ladder_swap_ctrl.sv
// Directed bench for ladder_swap_ctrl with a swap-mask scoreboard and delayed cswap/step responders.
module tb_ladder_swap_ctrl;

  localparam int WID  = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [WID-1:0]  scalar = '0;
  logic            cs_en;
  logic [WID-1:0]  cs_swap;
  logic            cs_vld = 1'b0;
  logic            step_en;
  logic            step_done = 1'b0;
  logic [IDXW-1:0] bit_idx;
  logic            busy;
  logic            done;
`ifdef LADDER_TMO_EN
  logic            err;
`endif

  int checks = 0;
  int failures = 0;
  logic [WID-1:0] exp_q[$];
  int n_step = 0;
  int n_done = 0;
  int sw_cnt = 0;
  int st_cnt = 0;
  bit step_resp_en = 1'b1;
  bit stray_en = 1'b0;

  always #5 clk = ~clk;

  ladder_swap_ctrl #(
    .WID(WID),
    .IDXW(IDXW)
`ifdef LADDER_TMO_EN
    , .TMO_CYC(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .scalar(scalar),
    .cs_en(cs_en),
    .cs_swap(cs_swap),
    .cs_vld(cs_vld),
    .step_en(step_en),
    .step_done(step_done),
    .bit_idx(bit_idx),
    .busy(busy),
    .done(done)
`ifdef LADDER_TMO_EN
    , .err(err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // cswap and ladder-step responders: answer 3 cycles after the request; optional stray pulses.
  always @(negedge clk) begin
    cs_vld = 1'b0;
    step_done = 1'b0;
    if (!rst) begin
      sw_cnt = 0;
      st_cnt = 0;
    end else begin
      if (sw_cnt > 0) begin
        sw_cnt--;
        if (sw_cnt == 0) cs_vld = 1'b1;
      end
      if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0 && step_resp_en) step_done = 1'b1;
      end
      if (stray_en && sw_cnt == 2) step_done = 1'b1;
      if (cs_en) sw_cnt = 3;
      if (step_en) begin
        st_cnt = 3;
        if (stray_en) cs_vld = 1'b1;
      end
    end
  end

  // Scoreboard: each issued swap pops one expected mask.
  always @(negedge clk) begin
    if (rst) begin
      if (cs_en) begin
        $display("swap idx=%0d mask=%02h", bit_idx, cs_swap);
        if (exp_q.size() == 0) check("swap_unexpected", 32'(exp_q.size()), 32'd1);
        else check("swap_mask", 32'(cs_swap), 32'(exp_q.pop_front()));
      end
      if (step_en) n_step++;
      if (done) n_done++;
    end
  end

  task automatic start_run(input logic [WID-1:0] s);
    logic p;
    p = 1'b0;
    for (int i = WID - 1; i >= 0; i--) begin
      exp_q.push_back({WID{s[i] ^ p}});
      p = s[i];
    end
    exp_q.push_back({WID{p}});
    n_step = 0;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    scalar = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_steps"}, 32'(n_step), 32'd8);
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
    check({tag, "_swaps_left"}, 32'(exp_q.size()), 32'd0);
    $display("run %s cycles=%0d steps=%0d", tag, cyc, n_step);
  endtask

  initial begin
    int cyc_b4, cyc_z, cyc_tmp, k, hold_steps;
    bit found;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({cs_en, step_en, busy, done, bit_idx, cs_swap}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    start_run(8'hB4);
    check("busy_after_start", 32'(busy), 32'd1);
    finish_run("b4", cyc_b4);
    check("idle_mask", 32'(cs_swap), 32'd0);

    start_run(8'h00);
    finish_run("zero", cyc_z);
    check("const_time", 32'(cyc_z), 32'(cyc_b4));

    start_run(8'hFF);
    finish_run("ff", cyc_tmp);

    stray_en = 1'b1;
    start_run(8'h5A);
    finish_run("stray", cyc_tmp);
    stray_en = 1'b0;
    check("stray_time", 32'(cyc_tmp), 32'(cyc_b4));

    start_run(8'hB4);
    repeat (20) @(negedge clk);
    start = 1'b1;
    scalar = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    finish_run("restart_ignored", cyc_tmp);

    // Abort while waiting for the step of bit 4.
    start_run(8'hB4);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      if (step_en === 1'b1 && bit_idx == 3'd4) found = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("reach_bit4", 32'(found), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", 32'({cs_en, step_en, busy, done, bit_idx, cs_swap}), 32'd0);
    exp_q.delete();
    hold_steps = n_step;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("no_pulses_after_abort", 32'(n_step), 32'(hold_steps));
    check("idle_after_abort", 32'({busy, done, cs_en}), 32'd0);
    start_run(8'hB4);
    finish_run("post_reset", cyc_tmp);

`ifdef LADDER_TMO_EN
    step_resp_en = 1'b0;
    start_run(8'hB4);
    k = 0;
    while (step_en !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("tmo_step_seen", 32'(step_en), 32'd1);
    repeat (16) @(negedge clk);
    check("tmo_err_early", 32'(err), 32'd0);
    @(negedge clk);
    check("tmo_err_set", 32'(err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("tmo_no_done", 32'(n_done), 32'd0);
    check("tmo_err_sticky", 32'(err), 32'd1);
    step_resp_en = 1'b1;
    exp_q.delete();
    start_run(8'h3C);
    check("tmo_err_cleared", 32'(err), 32'd0);
    finish_run("tmo_recover", cyc_tmp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
